// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: opcodes, next-PC select encodings and fetch FSM states.
package rv_pkg;

    localparam logic [6:0] RTYPE    = 7'b0110011;
    localparam logic [6:0] ITYPE    = 7'b0010011;
    localparam logic [6:0] STYPE    = 7'b0100011;
    localparam logic [6:0] BTYPE    = 7'b1100011;
    localparam logic [6:0] JTYPE    = 7'b1101111;
    localparam logic [6:0] UTYPE    = 7'b0110111;
    localparam logic [6:0] LWTYPE   = 7'b0000011;
    localparam logic [6:0] JALRTYPE = 7'b1100111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection with misaligned-target detection.
module pc_next_logic
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    // Reserved select falls back to sequential flow.
    always_comb begin
        next_pc = pc + XLEN'(4);
        case (PCSrc)
            PC_BRANCH: next_pc = pc + imm_ext;
            PC_JALR:   next_pc = alu_result & ~XLEN'(1);
            default:   next_pc = pc + XLEN'(4);
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register, fetch/exec/halt FSM and retire counter.
module fetch_unit
    import rv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [31:0]     instr,
    output logic [6:0]      op,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            exec_done,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_result,
    output logic            fault,
    output logic [31:0]     retired
);

    fetch_state_t    state;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    pc_next_logic #(.XLEN(XLEN)) u_pc_next (
        .pc         (pc),
        .PCSrc      (PCSrc),
        .imm_ext    (imm_ext),
        .alu_result (alu_result),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            retired     <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_valid) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_done) begin
                        retired     <= retired + 32'd1;
                        instr_valid <= 1'b0;
                        // A misaligned target freezes the PC at the offending instruction.
                        if (misaligned) begin
                            fault <= 1'b1;
                            state <= HALT;
                        end else begin
                            pc    <= next_pc;
                            state <= FETCH;
                        end
                    end
                end
                HALT: begin
                    instr_valid <= 1'b0;
                end
                default: begin
                    state       <= FETCH;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    // Request is gated by reset so memory never sees a stray address during reset.
    assign imem_req  = (state == FETCH) && !rst;
    assign imem_addr = pc;
    assign pc_plus4  = pc + XLEN'(4);

    assign op    = instr[6:0];
    assign func3 = instr[14:12];
    assign func7 = instr[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a wait-state memory model and an instruction scoreboard.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        exec_done;
    logic [1:0]  PCSrc;
    logic [31:0] imm_ext;
    logic [31:0] alu_result;
    logic        fault;
    logic [31:0] retired;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_retired = 0;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instr       (instr),
        .op          (op),
        .func3       (func3),
        .func7       (func7),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .exec_done   (exec_done),
        .PCSrc       (PCSrc),
        .imm_ext     (imm_ext),
        .alu_result  (alu_result),
        .fault       (fault),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_ivalid", 32'(instr_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_retired", retired, 32'd0);
    endtask

    // One instruction: memory responds after 'waits' cycles, then the datapath completes it.
    task automatic fetch_exec(input int waits, input logic [31:0] word, input logic [1:0] src,
                              input logic [31:0] imm, input logic [31:0] alu,
                              input logic [31:0] exp_addr, input logic [31:0] exp_next,
                              input bit exp_fault, input bit spurious);
        exp_t e;
        int   req_cycles;
        req_cycles = 0;
        for (int i = 0; i < waits; i++) begin
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr", imem_addr, exp_addr);
            check("wait_ivalid", 32'(instr_valid), 32'd0);
            if (imem_req) req_cycles++;
            tick();
        end
        check("resp_req", 32'(imem_req), 32'd1);
        check("resp_addr", imem_addr, exp_addr);
        if (imem_req) req_cycles++;
        check("req_cycles", 32'(req_cycles), 32'(waits + 1));
        imem_valid = 1'b1;
        imem_rdata = word;
        sb.push_back('{addr: exp_addr, word: word});
        tick();
        imem_valid = 1'b0;
        imem_rdata = 32'hx;
        check("exec_ivalid", 32'(instr_valid), 32'd1);
        check("exec_req", 32'(imem_req), 32'd0);
        check("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("instr", instr, e.word);
            check("op", 32'(op), 32'(e.word[6:0]));
            check("func3", 32'(func3), 32'(e.word[14:12]));
            check("func7", 32'(func7), 32'(e.word[31:25]));
            check("exec_pc", pc, e.addr);
            check("pc_plus4", pc_plus4, e.addr + 32'd4);
        end
        if (spurious) begin
            imem_valid = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
            tick();
            imem_valid = 1'b0;
            check("spur_instr", instr, word);
            check("spur_pc", pc, exp_addr);
            check("spur_ivalid", 32'(instr_valid), 32'd1);
        end
        exec_done  = 1'b1;
        PCSrc      = src;
        imm_ext    = imm;
        alu_result = alu;
        tick();
        exec_done = 1'b0;
        exp_retired = exp_retired + 32'd1;
        check("retired", retired, exp_retired);
        check("post_ivalid", 32'(instr_valid), 32'd0);
        if (exp_fault) begin
            check("halt_fault", 32'(fault), 32'd1);
            check("halt_req", 32'(imem_req), 32'd0);
            check("halt_pc", pc, exp_addr);
        end else begin
            check("next_fault", 32'(fault), 32'd0);
            check("next_req", 32'(imem_req), 32'd1);
            check("next_addr", imem_addr, exp_next);
        end
    endtask

    initial begin
        rst        = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        exec_done  = 1'b0;
        PCSrc      = 2'b00;
        imm_ext    = 32'h0;
        alu_result = 32'h0;
        tick();
        tick();
        check_reset_values();
        rst = 1'b0;
        #1;
        check("rel_req", 32'(imem_req), 32'd1);
        check("rel_addr", imem_addr, 32'h0);

        // Zero-wait addi, then a 3-wait-state fetch.
        fetch_exec(0, 32'h0050_0093, 2'b00, 32'h0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0);
        check("pc_after_first", pc, 32'h4);
        fetch_exec(3, 32'h00A0_0113, 2'b11, 32'h0, 32'h0, 32'h4, 32'h8, 1'b0, 1'b0);
        // JALR to 0x100, backward branch to 0xF8, JALR clearing bit 0 to 0x204.
        fetch_exec(1, 32'h0000_80E7, 2'b10, 32'h0, 32'h100, 32'h8, 32'h100, 1'b0, 1'b1);
        fetch_exec(0, 32'hFE00_0CE3, 2'b01, 32'hFFFF_FFF8, 32'h0, 32'h100, 32'hF8, 1'b0, 1'b0);
        fetch_exec(2, 32'h0000_8067, 2'b10, 32'h0, 32'h205, 32'hF8, 32'h204, 1'b0, 1'b0);
        fetch_exec(0, 32'h0020_0063, 2'b01, 32'h2, 32'h0, 32'h204, 32'h206, 1'b1, 1'b0);

        // HALT ignores everything.
        for (int i = 0; i < 4; i++) begin
            imem_valid = 1'b1;
            imem_rdata = 32'h1234_5678;
            exec_done  = 1'b1;
            PCSrc      = 2'b00;
            tick();
            check("halt_hold_req", 32'(imem_req), 32'd0);
            check("halt_hold_ivalid", 32'(instr_valid), 32'd0);
            check("halt_hold_pc", pc, 32'h204);
            check("halt_hold_instr", instr, 32'h0020_0063);
            check("halt_hold_fault", 32'(fault), 32'd1);
            check("halt_hold_retired", retired, exp_retired);
        end
        imem_valid = 1'b0;
        exec_done  = 1'b0;

        rst = 1'b1;
        #1;
        check_reset_values();
        tick();
        rst = 1'b0;
        exp_retired = 0;
        #1;

        // Spurious exec_done in FETCH, then PC wraparound from 0xFFFF_FFFC.
        exec_done = 1'b1;
        PCSrc     = 2'b01;
        imm_ext   = 32'h40;
        tick();
        exec_done = 1'b0;
        check("spur_done_pc", pc, 32'h0);
        check("spur_done_req", 32'(imem_req), 32'd1);
        check("spur_done_retired", retired, 32'd0);
        fetch_exec(0, 32'h0000_80E7, 2'b10, 32'h0, 32'hFFFF_FFFD, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        fetch_exec(1, 32'h0000_0013, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1);

        // Reset in the middle of a 3-wait fetch.
        tick();
        check("midwait_req", 32'(imem_req), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check_reset_values();
        tick();
        rst = 1'b0;
        exp_retired = 0;
        #1;
        fetch_exec(0, 32'h4000_D033, 2'b00, 32'h0, 32'h0, 32'h0, 32'h4, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
